alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
//  Sequential 16-bit ALU: producer side of the ALU_flags/ALU_ready interface read by the flags register.
//  Accepts an op on a start/busy handshake and runs logic/arith in 1 cycle, MUL/DIV iteratively.
//  On completion it pulses ALU_ready for one cycle with result and ALU_flags valid; the flags register latches on that pulse.
// PARAMETERS
//  WIDTH    16  operand/result width; MUL/DIV iteration count
//  OP_W     4   opcode width
// PORTS
//  clk        in   1      system clock, rising edge
//  reset      in   1      asynchronous, active-low reset (reset==0 clears all state)
//  start      in   1      request; sampled only in IDLE
//  op         in   OP_W   opcode, latched with start
//  a          in   WIDTH  operand A, latched with start
//  b          in   WIDTH  operand B, latched with start
//  busy       out  1      high whenever state != IDLE
//  result     out  WIDTH  primary result (MUL low word, DIV quotient)
//  result_hi  out  WIDTH  MUL high word / DIV remainder; 0 for other ops
//  ALU_flags  out  4      [3]=Z [2]=N [1]=C [0]=V
//  ALU_ready  out  1      one-cycle completion pulse
// BEHAVIOUR
//  - Reset (async, any state, incl. mid-MUL/DIV): state=IDLE, busy=0, ALU_ready=0, result=result_hi=0, ALU_flags=4'b0000; the op in flight is discarded.
//  - FSM: IDLE -start&single-cycle op-> DONE; IDLE -start&MUL/DIV-> ITER; ITER -count==WIDTH-1-> DONE; DONE -> IDLE (always).
//  - start sampled at edge k in IDLE: single-cycle op: ALU_ready=1 from edge k+1 to k+2; MUL/DIV: from edge k+WIDTH+1 to k+WIDTH+2.
//  - start outside IDLE is ignored (no queueing); op/a/b changes after edge k have no effect.
//  - result, result_hi, ALU_flags update at the edge that raises ALU_ready and hold until the next completion.
//  - Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT(a), 6 LSL(a by b[3:0]), 7 LSR(a by b[3:0]), 8 MUL (unsigned), 9 DIV (unsigned), 10-15 illegal.
//  - Z = (result==0); N = result[WIDTH-1] for every op.
//  - ADD: C = carry-out, V = signed overflow. SUB (a-b): C = 1 on borrow (a<b unsigned), V = signed overflow.
//  - AND/OR/XOR/NOT: C=0, V=0. Shifts: C = last bit shifted out (0 if amount is 0), V=0.
//  - MUL: 2*WIDTH-bit product {result_hi,result}, shift-add one bit/cycle; C = (result_hi!=0), V=0.
//  - DIV: restoring, one quotient bit/cycle; b==0 -> result=all ones, result_hi=a, V=1, C=0; still WIDTH+1 cycles.
//  - Illegal opcode: single-cycle path, result=result_hi=0, ALU_flags=4'b1001 (Z,V).
//  - Arithmetic is modulo 2^WIDTH; no saturation.
// CONFIGURATION
//  - ALU_SEQ_DIV_EN defined: DIV implemented as above.
//  - Not defined: no divider logic; op 9 is treated as an illegal opcode (1 cycle, result 0, flags 4'b1001).
// STRUCTURE
//  - Package alu_pkg: opcode localparams (OP_ADD..OP_DIV), flag index constants (FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0), FSM state encodings.
//  - Sub-module alu_muldiv_core: iterative MUL/DIV datapath (accumulator, shift registers, counter) with load/step/done.
//  - Top holds the FSM, single-cycle combinational ops, flag generation and output registers.
// TESTING
//  - Reset: hold reset=0 for 25 ns with start=1 -> busy=0, ALU_ready=0, ALU_flags=0, result=0 throughout.
//  - ADD 16'h7FFF+16'h0001 -> one ALU_ready pulse 1 cycle after start, result=16'h8000, flags=4'b0101 (N,V).
//  - SUB 16'h0003-16'h0005 -> result=16'hFFFE, flags=4'b0110 (N,C); SUB 5-5 -> result 0, flags=4'b1000.
//  - MUL 16'h1234*16'h0100 -> ALU_ready at start+17 cycles, result=16'h3400, result_hi=16'h0012, flags=4'b0010 (C); start during busy ignored.
//  - DIV 100/7 -> quotient 14, remainder 2, flags 0; DIV by 0 -> result 16'hFFFF, result_hi=a, flags=4'b0101 (N,V); without ALU_SEQ_DIV_EN -> 1 cycle, flags 4'b1001.
//  - Drop reset to 0 mid-MUL (cycle 8) -> immediate IDLE, outputs zero, no ALU_ready pulse; next ADD completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the sequential ALU: opcodes, flag bit positions and FSM encodings.
// No configuration macros are consumed here; see alu_seq.sv for ALU_SEQ_DIV_EN.
`timescale 1ns/1ps

package alu_pkg;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_NOT = 4'd5;
   localparam logic [3:0] OP_LSL = 4'd6;
   localparam logic [3:0] OP_LSR = 4'd7;
   localparam logic [3:0] OP_MUL = 4'd8;
   localparam logic [3:0] OP_DIV = 4'd9;

   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef logic [1:0] alu_state_t;

   localparam alu_state_t ST_IDLE = 2'd0;
   localparam alu_state_t ST_ITER = 2'd1;
   localparam alu_state_t ST_DONE = 2'd2;

   // Places the four condition bits at their architectural positions.
   function automatic logic [3:0] pack_flags(input logic z, input logic n,
                                             input logic c, input logic v);
      logic [3:0] f;
      f         = 4'b0000;
      f[FLAG_Z] = z;
      f[FLAG_N] = n;
      f[FLAG_C] = c;
      f[FLAG_V] = v;
      return f;
   endfunction

endpackage

// File: rtl/alu_muldiv_core.sv
// Iterative datapath: shift-add unsigned multiply and restoring unsigned divide, one bit per step.
// Divider logic exists only when ALU_SEQ_DIV_EN is defined.
`timescale 1ns/1ps

module alu_muldiv_core #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic             i_step,
`ifdef ALU_SEQ_DIV_EN
   input  logic             i_is_div,
`endif
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_done,
   output logic [WIDTH-1:0] o_lo,
   output logic [WIDTH-1:0] o_hi
);
   import alu_pkg::*;

   localparam int CNT_W = $clog2(WIDTH);

   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] r_opnd;
   logic [WIDTH-1:0] w_hi_nxt;
   logic [WIDTH-1:0] w_lo_nxt;
   logic [WIDTH:0]   w_mul_sum;

   // MUL: r_lo holds the multiplier and shifts right while product bits enter from r_hi.
   assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});

`ifdef ALU_SEQ_DIV_EN
   logic           r_is_div;
   logic [WIDTH:0] w_div_shift;
   logic [WIDTH:0] w_div_trial;
   logic           w_div_ok;

   // DIV: r_hi is the partial remainder, r_lo shifts the dividend out and quotient bits in.
   // A zero divisor always "fits", giving an all-ones quotient and the dividend as remainder.
   assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
   assign w_div_trial = w_div_shift - {1'b0, r_opnd};
   assign w_div_ok    = (w_div_shift >= {1'b0, r_opnd});

   always_comb begin
      w_hi_nxt = w_mul_sum[WIDTH:1];
      w_lo_nxt = {w_mul_sum[0], r_lo[WIDTH-1:1]};
      if (r_is_div) begin
         w_hi_nxt = w_div_ok ? w_div_trial[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
         w_lo_nxt = {r_lo[WIDTH-2:0], w_div_ok};
      end
   end
`else
   always_comb begin
      w_hi_nxt = w_mul_sum[WIDTH:1];
      w_lo_nxt = {w_mul_sum[0], r_lo[WIDTH-1:1]};
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt  <= '0;
         r_hi   <= '0;
         r_lo   <= '0;
         r_opnd <= '0;
      end else if (i_load) begin
         r_cnt  <= '0;
         r_hi   <= '0;
         r_lo   <= i_a;
         r_opnd <= i_b;
      end else if (i_step) begin
         r_cnt  <= r_cnt + 1'b1;
         r_hi   <= w_hi_nxt;
         r_lo   <= w_lo_nxt;
      end
   end

`ifdef ALU_SEQ_DIV_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      r_is_div <= 1'b0;
      else if (i_load) r_is_div <= i_is_div;
   end
`endif

   assign o_done = (r_cnt == CNT_W'(WIDTH-1));
   assign o_lo   = r_lo;
   assign o_hi   = r_hi;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU top: start/busy intake, FSM, single-cycle ops, flag generation, ALU_ready pulse.
// Define ALU_SEQ_DIV_EN to build the divider; otherwise opcode 9 is treated as illegal.
`timescale 1ns/1ps

module alu_seq #(
   parameter int WIDTH = 16,
   parameter int OP_W  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic [3:0]       ALU_flags,
   output logic             ALU_ready
);
   import alu_pkg::*;

   alu_state_t       r_state;
   logic [OP_W-1:0]  r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_result;
   logic [WIDTH-1:0] r_result_hi;
   logic [3:0]       r_flags;
   logic             r_ready;

   logic             w_is_iter;
   logic             w_load;
   logic             w_core_done;
   logic [WIDTH-1:0] w_core_lo;
   logic [WIDTH-1:0] w_core_hi;
   logic [WIDTH-1:0] w_res;
   logic [WIDTH-1:0] w_res_hi;
   logic             w_c;
   logic             w_v;
   logic             w_illegal;
   logic [3:0]       w_flags;

`ifdef ALU_SEQ_DIV_EN
   assign w_is_iter = (op == OP_MUL) || (op == OP_DIV);
`else
   assign w_is_iter = (op == OP_MUL);
`endif
   assign w_load = (r_state == ST_IDLE) && start && w_is_iter;

   alu_muldiv_core #(.WIDTH(WIDTH)) u_core (
      .clk      (clk),
      .reset    (reset),
      .i_load   (w_load),
      .i_step   (r_state == ST_ITER),
`ifdef ALU_SEQ_DIV_EN
      .i_is_div (op == OP_DIV),
`endif
      .i_a      (a),
      .i_b      (b),
      .o_done   (w_core_done),
      .o_lo     (w_core_lo),
      .o_hi     (w_core_hi)
   );

   // Result selection from the latched op; only consumed in DONE.
   always_comb begin
      w_res     = '0;
      w_res_hi  = '0;
      w_c       = 1'b0;
      w_v       = 1'b0;
      w_illegal = 1'b0;
      case (r_op)
         OP_ADD: begin
            {w_c, w_res} = {1'b0, r_a} + {1'b0, r_b};
            w_v = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
         end
         OP_SUB: begin
            w_res = r_a - r_b;
            w_c   = (r_a < r_b);
            w_v   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
         end
         OP_AND: w_res = r_a & r_b;
         OP_OR:  w_res = r_a | r_b;
         OP_XOR: w_res = r_a ^ r_b;
         OP_NOT: w_res = ~r_a;
         // The extra bit beside the operand catches the last bit shifted out.
         OP_LSL: {w_c, w_res} = {1'b0, r_a} << r_b[3:0];
         OP_LSR: {w_res, w_c} = {r_a, 1'b0} >> r_b[3:0];
         OP_MUL: begin
            w_res    = w_core_lo;
            w_res_hi = w_core_hi;
            w_c      = (w_core_hi != '0);
         end
`ifdef ALU_SEQ_DIV_EN
         OP_DIV: begin
            w_res    = w_core_lo;
            w_res_hi = w_core_hi;
            w_v      = (r_b == '0);
         end
`endif
         default: w_illegal = 1'b1;
      endcase
      w_flags = w_illegal ? pack_flags(1'b1, 1'b0, 1'b0, 1'b1)
                          : pack_flags(w_res == '0, w_res[WIDTH-1], w_c, w_v);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_op        <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_result    <= '0;
         r_result_hi <= '0;
         r_flags     <= 4'b0000;
         r_ready     <= 1'b0;
      end else begin
         r_ready <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_op    <= op;
                  r_a     <= a;
                  r_b     <= b;
                  r_state <= w_is_iter ? ST_ITER : ST_DONE;
               end
            end
            ST_ITER: begin
               if (w_core_done) r_state <= ST_DONE;
            end
            ST_DONE: begin
               r_result    <= w_res;
               r_result_hi <= w_res_hi;
               r_flags     <= w_flags;
               r_ready     <= 1'b1;
               r_state     <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy      = (r_state != ST_IDLE);
   assign result    = r_result;
   assign result_hi = r_result_hi;
   assign ALU_flags = r_flags;
   assign ALU_ready = r_ready;

endmodule
